// File: rtl/ky32_mem_arbiter_if.sv
// ky32_mem_arbiter_if: bundle of the fetch port (I), the load/store port (D)
// and the shared memory bus (m_*) around ky32_mem_arbiter.
//
// Handshake: a requester raises req with a stable payload and holds both
// until the one-cycle done pulse. It either drops req in the done cycle or
// keeps it high to issue the next request. On the memory side, m_req is held
// high with a stable payload until the one-cycle m_ack, and m_rdata is valid
// with m_ack.
interface ky32_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata
    );

    // Requester and memory side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/ky32_mem_arbiter.sv
// ky32_mem_arbiter: shares one memory bus between the KY32 fetch port (I)
// and load/store port (D). Each grant runs IDLE -> BUS -> RESP, with a
// one-cycle done pulse returned to the winner.
// Build option KY32_ARB_RR_EN: round-robin arbitration instead of
// D-priority with the starvation guard.
module ky32_mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int STARVE = 4
) (
    input  logic                clk,
    input  logic                rst,
    ky32_mem_arbiter_if.slave   bus,
    output logic                busy,
    output logic                owner,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   grant_i;
    logic   grant_d;

    assign dbg_state = state;

`ifdef KY32_ARB_RR_EN
    // Round-robin: on a tie, the port that did not win last time goes first.
    always_comb begin
        grant_i = bus.i_req && (!bus.d_req || owner);
        grant_d = bus.d_req && !grant_i;
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    logic [3:0] starve_cnt;

    // D wins unless I has watched STARVE D grants in a row while waiting.
    always_comb begin
        grant_i = bus.i_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
        grant_d = bus.d_req && !grant_i;
    end

    // Count D grants that overtake a waiting I; any I grant or an idle
    // cycle without an I request clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!bus.i_req || grant_i) begin
                starve_cnt <= 4'd0;
            end else if (grant_d) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    // Transaction sequencer: latch the winner, hold m_req until m_ack,
    // capture read data, then pulse done to the owner for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            bus.i_done  <= 1'b0;
            bus.d_done  <= 1'b0;
            busy        <= 1'b0;
            owner       <= 1'b0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        state       <= BUS;
                        bus.m_req   <= 1'b1;
                        busy        <= 1'b1;
                        owner       <= grant_d;
                        bus.m_we    <= grant_d & bus.d_we;
                        bus.m_addr  <= grant_d ? bus.d_addr : bus.i_addr;
                        bus.m_wdata <= grant_d ? bus.d_wdata : '0;
                    end
                end
                BUS: begin
                    if (bus.m_ack) begin
                        state     <= RESP;
                        bus.m_req <= 1'b0;
                        if (owner) begin
                            bus.d_rdata <= bus.m_rdata;
                            bus.d_done  <= 1'b1;
                        end else begin
                            bus.i_rdata <= bus.m_rdata;
                            bus.i_done  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    bus.m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ky32_mem_arbiter.sv
// tb_ky32_mem_arbiter: directed bench for ky32_mem_arbiter with a memory
// responder and an expected-grant queue. Honours KY32_ARB_RR_EN for the
// grant-order expectations.
module tb_ky32_mem_arbiter;

    localparam int W = 66;   // {port(1=D), we, addr[31:0], wdata[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ky32_mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    logic       busy;
    logic       owner;
    logic [1:0] dbg_state;

    ky32_mem_arbiter #(.AW(32), .DW(32), .STARVE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    // ---------------- memory responder ----------------
    logic        resp_ack  = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] resp_data = 32'h0;
    int          resp_k    = 0;
    logic        fixed_en  = 1'b0;

    assign bus.m_ack   = resp_ack | stray_ack;
    assign bus.m_rdata = resp_data;

    function automatic logic [31:0] rdata_fn(input logic [31:0] addr);
        if (fixed_en) return 32'hDEAD_BEEF;
        return {addr[15:0], addr[15:0] ^ 16'hBEEF};
    endfunction

    // Ack k cycles after m_req is first seen, for exactly one cycle.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_ack) begin
                resp_ack = 1'b0;
                wait_cnt = 0;
            end else if (bus.m_req) begin
                if (wait_cnt >= resp_k) begin
                    resp_ack  = 1'b1;
                    resp_data = rdata_fn(bus.m_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur = '0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mreq_cycles = 0;
    logic prev_mreq = 1'b0;
    logic i_done_seen = 1'b0;
    logic d_done_seen = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, and score grants/dones.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.m_req) mreq_cycles++;
        i_done_seen = bus.i_done;
        d_done_seen = bus.d_done;
        if (bus.m_req && !prev_mreq) begin
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", W'(exp_q.size()), W'(1));
            end else begin
                cur = exp_q.pop_front();
                chk("grant", {owner, bus.m_we, bus.m_addr, bus.m_wdata}, cur);
                chk("grant_busy", W'(busy), W'(1));
            end
        end
        prev_mreq = bus.m_req;
        if (bus.i_done || bus.d_done) begin
            chk("done_port", W'({bus.d_done, bus.i_done}), cur[65] ? W'(2'b10) : W'(2'b01));
            chk("rdata", W'(cur[65] ? bus.d_rdata : bus.i_rdata), W'(rdata_fn(cur[63:32])));
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(i_done_seen || d_done_seen) && n < budget);
        chk("done_within_budget", W'(i_done_seen | d_done_seen), W'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int n;
        int n_total;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;

        // Reset values.
        tick();
        tick();
        chk("reset_bus", {bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata}, '0);
        chk("reset_rdata", W'({bus.i_rdata, bus.d_rdata}), '0);
        chk("reset_flags", W'({bus.i_done, bus.d_done, busy, owner, dbg_state}), '0);
        rst = 1'b1;

        // 1: I-only read, k = 2, fixed read data.
        fixed_en = 1'b1;
        resp_k = 2;
        mreq_cycles = 0;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h100;
        exp_q.push_back({1'b0, 1'b0, 32'h100, 32'h0});
        wait_done(20, n);
        chk("t1_latency", W'(n), W'(4));
        chk("t1_mreq_cycles", W'(mreq_cycles), W'(3));
        chk("t1_i_rdata", W'(bus.i_rdata), W'(32'hDEAD_BEEF));
        bus.i_req = 1'b0;
        tick();
        chk("t1_back_idle", W'({bus.i_done, bus.d_done, busy, dbg_state}), '0);
        fixed_en = 1'b0;

        // 2: simultaneous I read and D store, k = 0: D first, then I.
        resp_k = 0;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h200;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h300;
        bus.d_wdata = 32'h1234_5678;
        exp_q.push_back({1'b1, 1'b1, 32'h300, 32'h1234_5678});
        exp_q.push_back({1'b0, 1'b0, 32'h200, 32'h0});
        wait_done(20, n);
        chk("t2_d_latency", W'(n), W'(2));
        chk("t2_d_done", W'(d_done_seen), W'(1));
        n_total = n;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        wait_done(20, n);
        chk("t2_i_done", W'(i_done_seen), W'(1));
        n_total += n;
        chk("t2_total_cycles", W'(n_total + 1), W'(6));
        bus.i_req = 1'b0;
        tick();

        // 3: both held continuously, k = 0: grant order.
        bus.i_req = 1'b1;
        bus.i_addr = 32'h700;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h600;
        bus.d_wdata = 32'h55AA;
        for (int g = 0; g < 10; g++) begin
`ifdef KY32_ARB_RR_EN
            if (g % 2 == 1)
`else
            if (g % 5 == 4)
`endif
                exp_q.push_back({1'b0, 1'b0, 32'h700, 32'h0});
            else
                exp_q.push_back({1'b1, 1'b0, 32'h600, 32'h55AA});
        end
        for (int g = 0; g < 10; g++) wait_done(20, n);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        chk("t3_all_granted", W'(exp_q.size()), W'(0));

        // 4: reset while in BUS aborts; held request restarts afterwards.
        resp_k = 5;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h400;
        exp_q.push_back({1'b0, 1'b0, 32'h400, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 32'h400, 32'h0});
        tick();
        tick();
        chk("t4_in_bus", W'({bus.m_req, dbg_state}), W'({1'b1, 2'd1}));
        rst = 1'b0;
        #1;
        chk("t4_abort", W'({bus.m_req, busy, bus.i_done, bus.d_done, dbg_state}), '0);
        tick();
        rst = 1'b1;
        resp_k = 1;
        wait_done(20, n);
        chk("t4_restart_latency", W'(n), W'(3));
        bus.i_req = 1'b0;
        tick();

        // 5: stray ack in IDLE ignored; I drops req mid-BUS, still completes.
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        chk("t5_stray_ignored", W'({bus.m_req, busy, bus.i_done, bus.d_done, dbg_state}), '0);
        resp_k = 3;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h500;
        exp_q.push_back({1'b0, 1'b0, 32'h500, 32'h0});
        tick();
        tick();
        bus.i_req = 1'b0;
        bus.i_addr = 32'hFFF;
        tick();
        chk("t5_addr_held", W'({bus.m_req, bus.m_addr}), W'({1'b1, 32'h500}));
        wait_done(20, n);
        chk("t5_done_latency", W'(n), W'(2));
        tick();
        chk("t5_no_regrant", W'({bus.m_req, busy}), '0);

        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
